// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, handshakes with instruction memory and
// loads the IF/ID register, with hazard stalls, a one-entry skid buffer and branch redirects.
module if_fetch_stage #(
  parameter int unsigned  n        = 32,
  parameter logic [n-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         branch_taken,
  input  logic [n-1:0] branch_base,
  input  logic [n-1:0] branch_offset,
  output logic         imem_req,
  output logic [n-1:0] imem_addr,
  input  logic         imem_ready,
  input  logic [31:0]  imem_data,
  output logic [n-1:0] ifid_pc,
  output logic [n-1:0] ifid_pc4,
  output logic [31:0]  ifid_inst,
  output logic         ifid_valid,
  output logic         target_misaligned
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [n-1:0] PC_STEP = n'(4);

  state_t       state_q, state_d;
  logic [n-1:0] pc_q, pc_d;
  logic [31:0]  hold_inst_q, hold_inst_d;
  logic [n-1:0] ifid_pc_q, ifid_pc_d;
  logic [n-1:0] ifid_pc4_q, ifid_pc4_d;
  logic [31:0]  ifid_inst_q, ifid_inst_d;
  logic         ifid_valid_q, ifid_valid_d;
  logic         misaligned_q, misaligned_d;
  logic [n-1:0] target_s;
  logic [n-1:0] pc_plus4_s;

  assign target_s   = branch_base + branch_offset;
  assign pc_plus4_s = pc_q + PC_STEP;

  // Request is decoded from registered state only, so memory sees no input-to-output path.
  assign imem_req          = (state_q == FETCH);
  assign imem_addr         = pc_q;
  assign ifid_pc           = ifid_pc_q;
  assign ifid_pc4          = ifid_pc4_q;
  assign ifid_inst         = ifid_inst_q;
  assign ifid_valid        = ifid_valid_q;
  assign target_misaligned = misaligned_q;

  // Next-state logic: redirect beats stall, stall beats normal fetch.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_inst_d  = hold_inst_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_inst_d  = ifid_inst_q;
    ifid_valid_d = ifid_valid_q;
    misaligned_d = 1'b0;

    if (branch_taken) begin
      pc_d         = {target_s[n-1:2], 2'b00};
      misaligned_d = target_s[1];
      ifid_valid_d = 1'b0;
      hold_inst_d  = 32'h0000_0000;
      state_d      = FETCH;
    end else begin
      case (state_q)
        BOOT: begin
          state_d = FETCH;
        end
        FETCH: begin
          if (imem_ready && !stall) begin
            ifid_pc_d    = pc_q;
            ifid_pc4_d   = pc_plus4_s;
            ifid_inst_d  = imem_data;
            ifid_valid_d = 1'b1;
            pc_d         = pc_plus4_s;
          end else if (imem_ready) begin
            // Fetched word arrives during a stall: park it until the stall drops.
            hold_inst_d = imem_data;
            state_d     = HOLD;
          end else if (!stall) begin
            ifid_valid_d = 1'b0;
          end else begin
            state_d = FETCH;
          end
        end
        HOLD: begin
          if (!stall) begin
            ifid_pc_d    = pc_q;
            ifid_pc4_d   = pc_plus4_s;
            ifid_inst_d  = hold_inst_q;
            ifid_valid_d = 1'b1;
            pc_d         = pc_plus4_s;
            state_d      = FETCH;
          end else begin
            state_d = HOLD;
          end
        end
        default: begin
          state_d = BOOT;
        end
      endcase
    end
  end

  // State and pipeline registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      hold_inst_q  <= 32'h0000_0000;
      ifid_pc_q    <= '0;
      ifid_pc4_q   <= '0;
      ifid_inst_q  <= 32'h0000_0000;
      ifid_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_inst_q  <= hold_inst_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_inst_q  <= ifid_inst_d;
      ifid_valid_q <= ifid_valid_d;
      misaligned_q <= misaligned_d;
    end
  end

endmodule
